step_sequencer: RTL and testbench
=================================

# step_sequencer

Multicycle step sequencer for the CSC317 processor control path. It consumes the instruction opcode and memory-wait status, and produces the current execution step (1..5). Unlike the fixed 1→5 free-running step counter, it holds a step while memory stalls, ends each instruction at its class-dependent last step, and supports halt/resume. It also emits IR-load and retire strobes and keeps a retired-instruction count for the rest of the control unit.

## Interface
- COUNT_WIDTH, 16, width of retired-instruction counter
- Clock  in  1  rising-edge clock, sole clock
- Reset  in  1  synchronous, active-high; dominates all other inputs
- Opcode  in  4  IR opcode; valid from step 2 onward
- MemWait  in  1  memory not ready; honoured only in stall-able steps
- Resume  in  1  leave halted state
- Step  out  3  current step 1..5; 0 while halted (registered)
- StepOneHot  out  5  bit i = (Step == i+1); all zero when halted
- IRLoad  out  1  IR capture strobe (combinational)
- Stall  out  1  step held this cycle due to MemWait (combinational)
- Retire  out  1  last step of an instruction completes this cycle (combinational)
- InstrCount  out  COUNT_WIDTH  retired instructions, wraps (registered)
- Halted  out  1  sequencer stopped (registered)

## Operation
- States: RUN (Step 1..5) and HALTED.
- Instruction class is decoded from Opcode in step 2 and latched at the end of step 2. Later steps use the latched class, not live Opcode.
  - 00xx ALU/NOP: last step 4
  - 01xx load: last step 5
  - 10xx store: last step 4
  - 110x branch/jump: last step 3
  - 1110 reserved: treated as branch class, last step 3
  - 1111 HALT: last step 2, then HALTED
- Stall-able steps:
  - step 1 (fetch), all classes
  - step 4, load/store classes only
  - MemWait is ignored in every other step.
- Stall = RUN & stall-able step & MemWait. While Stall, Step holds.
- IRLoad = RUN & Step==1 & !MemWait.
- Retire = RUN & Step==last step for the class & !Stall.
- Next step, in priority order:
  - Reset → 1
  - Stall → hold
  - Retire with HALT class → HALTED
  - Retire otherwise → 1
  - else Step+1
- HALTED: Step=0; MemWait and Opcode are ignored. Resume=1 → RUN with Step=1 next cycle.
- InstrCount increments by 1 on each Retire, including HALT. It wraps from 2^COUNT_WIDTH−1 to 0.
- Step never takes the values 6 or 7. Any illegal encoding recovers to Step=1 on the next edge.

## Timing
- Reset values, one edge after Reset is sampled high:
  - Step=1, StepOneHot=00001
  - InstrCount=0, Halted=0, latched class=ALU
- IRLoad, Stall and Retire are forced to 0 in any cycle where Reset=1.
- Reset mid-instruction or while halted abandons the instruction. No Retire is issued, InstrCount is cleared, and Step=1 after the edge.
- Latency: an unstalled instruction occupies exactly last-step cycles. Each stall cycle adds one cycle.
- Retire and Step==1 never occur in the same cycle, except a retire that itself ends in step 1 (impossible; minimum last step is 2).
- Halted rises on the edge after the HALT Retire. Halted falls, with Step=1, on the edge after Resume is sampled.
- Resume sampled during RUN has no effect.
- MemWait in step 4 with a 1-step pulse: exactly one extra cycle in step 4.

## Test plan
- Reset then ALU opcode 0010, MemWait=0 → Step 1,2,3,4,1; IRLoad high in cycle 1 only; Retire in cycle 4; InstrCount=1.
- Load 0100 with MemWait high for 2 cycles in step 1 and 3 cycles in step 4 → Step 1,1,1,2,3,4,4,4,4,5,1; Stall high 5 cycles; one Retire.
- Branch 1100 with MemWait held high in steps 2–3 → no stall; Step 1,2,3,1; Retire at step 3.
- HALT 1111 → Retire at step 2, then Halted=1, Step=0 with MemWait toggling. Resume pulse → Step=1 next cycle, Halted=0, InstrCount=1.
- COUNT_WIDTH=4, 16 back-to-back branch instructions → InstrCount wraps 15→0.
- Assert Reset during step 4 of a load with MemWait=1 → no Retire; Step=1, InstrCount=0, Stall=0 during the Reset cycle.

Source files
------------

// File: rtl/step_sequencer.sv
// Multicycle step sequencer: walks steps 1..5 per instruction, holds on memory
// stalls, ends at the class-dependent last step, and supports HALT/Resume.
module step_sequencer #(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic [3:0]             Opcode,
   input  logic                   MemWait,
   input  logic                   Resume,
   output logic [2:0]             Step,
   output logic [4:0]             StepOneHot,
   output logic                   IRLoad,
   output logic                   Stall,
   output logic                   Retire,
   output logic [COUNT_WIDTH-1:0] InstrCount,
   output logic                   Halted
);

   typedef enum logic {S_RUN, S_HALTED} state_e;
   typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_HALT} cls_e;

   state_e                 state_q, state_d;
   cls_e                   cls_q, cls_d, cls_cur;
   logic [2:0]             step_q, step_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   run, legal, stall_en, stall, retire;

   function automatic cls_e decode(input logic [3:0] op);
      casez (op)
         4'b00??: decode = C_ALU;
         4'b01??: decode = C_LOAD;
         4'b10??: decode = C_STORE;
         4'b1111: decode = C_HALT;
         default: decode = C_BRANCH;
      endcase
   endfunction

   function automatic logic [2:0] last_step(input cls_e c);
      case (c)
         C_LOAD:   last_step = 3'd5;
         C_BRANCH: last_step = 3'd3;
         C_HALT:   last_step = 3'd2;
         default:  last_step = 3'd4;
      endcase
   endfunction

   // Step 2 decides its own retire from live Opcode; later steps use the latch.
   always_comb begin
      run      = (state_q == S_RUN);
      legal    = (step_q >= 3'd1) && (step_q <= 3'd5);
      cls_cur  = (step_q == 3'd2) ? decode(Opcode) : cls_q;
      stall_en = (step_q == 3'd1) ||
                 ((step_q == 3'd4) && (cls_q == C_LOAD || cls_q == C_STORE));
      stall    = !Reset && run && stall_en && MemWait;
      retire   = !Reset && run && legal && !stall && (step_q == last_step(cls_cur));
      IRLoad   = !Reset && run && (step_q == 3'd1) && !MemWait;
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      cls_d   = cls_q;
      cnt_d   = cnt_q;
      if (!run) begin
         step_d = 3'd0;
         if (Resume) begin
            state_d = S_RUN;
            step_d  = 3'd1;
         end
      end else begin
         if (step_q == 3'd2) cls_d = cls_cur;
         if (!legal) begin
            step_d = 3'd1;
         end else if (stall) begin
            step_d = step_q;
         end else if (retire) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
            if (cls_cur == C_HALT) begin
               state_d = S_HALTED;
               step_d  = 3'd0;
            end else begin
               step_d = 3'd1;
            end
         end else begin
            step_d = (step_q == 3'd5) ? 3'd1 : step_q + 3'd1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_RUN;
         step_q  <= 3'd1;
         cls_q   <= C_ALU;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cls_q   <= cls_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      StepOneHot = '0;
      for (int i = 0; i < 5; i++) StepOneHot[i] = (step_q == 3'(i + 1));
   end

   assign Step       = step_q;
   assign Stall      = stall;
   assign Retire     = retire;
   assign InstrCount = cnt_q;
   assign Halted     = (state_q == S_HALTED);

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios plus a random run against an
// integer-level model of the step rules.
module tb_step_sequencer;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, mw, res;
   logic [3:0]    op;
   logic [2:0]    Step;
   logic [4:0]    StepOneHot;
   logic          IRLoad, Stall, Retire, Halted;
   logic [CW-1:0] InstrCount;

   int checks = 0;
   int errors = 0;

   step_sequencer #(.COUNT_WIDTH(CW)) dut (
      .Clock(clk), .Reset(rst), .Opcode(op), .MemWait(mw), .Resume(res),
      .Step(Step), .StepOneHot(StepOneHot), .IRLoad(IRLoad), .Stall(Stall),
      .Retire(Retire), .InstrCount(InstrCount), .Halted(Halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; mw = 1'b0; res = 1'b0; op = 4'd0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; mw = 1'b1; res = 1'b1; op = 4'b0100;
      @(negedge clk);
      checks++;
      if ({IRLoad, Stall, Retire} !== 3'b000) begin
         errors++;
         $display("FAIL reset_strobes: got %b want 000", {IRLoad, Stall, Retire});
      end
      tick();
      rst = 1'b0; mw = 1'b0; res = 1'b0;
      @(negedge clk);
      checks++;
      if ({Step, StepOneHot, InstrCount, Halted} !== {3'd1, 5'b00001, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got step=%0d oh=%b cnt=%0d halt=%b want 1 00001 0 0",
                  Step, StepOneHot, InstrCount, Halted);
      end
   endtask

   task automatic test_alu();
      int es[5] = '{1, 2, 3, 4, 1};
      bit ei[5] = '{1, 0, 0, 0, 1};
      bit er[5] = '{0, 0, 0, 1, 0};
      do_reset();
      op = 4'b0010; mw = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if ({Step, IRLoad, Stall, Retire} !== {3'(es[c]), ei[c], 1'b0, er[c]}) begin
            errors++;
            $display("FAIL alu c%0d: got step=%0d irl=%b stl=%b ret=%b want %0d %b 0 %b",
                     c, Step, IRLoad, Stall, Retire, es[c], ei[c], er[c]);
         end
         if (c < 4) tick();
      end
      checks++;
      if (InstrCount !== 4'd1) begin
         errors++;
         $display("FAIL alu_count: got %0d want 1", InstrCount);
      end
   endtask

   task automatic test_load_stall();
      int es[11] = '{1, 1, 1, 2, 3, 4, 4, 4, 4, 5, 1};
      bit em[11] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
      bit ei[11] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
      bit er[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      do_reset();
      op = 4'b0100;
      for (int c = 0; c < 11; c++) begin
         mw = em[c];
         @(negedge clk);
         checks++;
         if ({Step, IRLoad, Stall, Retire} !== {3'(es[c]), ei[c], em[c], er[c]}) begin
            errors++;
            $display("FAIL load c%0d: got step=%0d irl=%b stl=%b ret=%b want %0d %b %b %b",
                     c, Step, IRLoad, Stall, Retire, es[c], ei[c], em[c], er[c]);
         end
         tick();
      end
   endtask

   task automatic test_branch();
      int es[4] = '{1, 2, 3, 1};
      bit em[4] = '{0, 1, 1, 0};
      bit ei[4] = '{1, 0, 0, 1};
      bit er[4] = '{0, 0, 1, 0};
      do_reset();
      op = 4'b1100;
      for (int c = 0; c < 4; c++) begin
         mw = em[c];
         @(negedge clk);
         checks++;
         if ({Step, IRLoad, Stall, Retire} !== {3'(es[c]), ei[c], 1'b0, er[c]}) begin
            errors++;
            $display("FAIL branch c%0d: got step=%0d irl=%b stl=%b ret=%b want %0d %b 0 %b",
                     c, Step, IRLoad, Stall, Retire, es[c], ei[c], er[c]);
         end
         tick();
      end
   endtask

   task automatic test_halt();
      do_reset();
      op = 4'b1111; mw = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      checks++;
      if ({Step, Retire, Halted} !== {3'd2, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL halt_retire: got step=%0d ret=%b halt=%b want 2 1 0", Step, Retire, Halted);
      end
      tick();
      for (int c = 0; c < 5; c++) begin
         op = 4'($urandom_range(0, 15));
         mw = 1'($urandom_range(0, 1));
         res = (c == 4);
         @(negedge clk);
         checks++;
         if ({Step, StepOneHot, Halted, IRLoad, Stall, Retire} !== {3'd0, 5'd0, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL halted c%0d: got step=%0d oh=%b halt=%b irl=%b stl=%b ret=%b want 0 00000 1 0 0 0",
                     c, Step, StepOneHot, Halted, IRLoad, Stall, Retire);
         end
         tick();
      end
      res = 1'b0; mw = 1'b0;
      @(negedge clk);
      checks++;
      if ({Step, Halted, InstrCount, IRLoad} !== {3'd1, 1'b0, 4'd1, 1'b1}) begin
         errors++;
         $display("FAIL resume: got step=%0d halt=%b cnt=%0d irl=%b want 1 0 1 1",
                  Step, Halted, InstrCount, IRLoad);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      op = 4'b1100; mw = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick(); tick(); tick();
         @(negedge clk);
         checks++;
         if (InstrCount !== 4'(i % 16)) begin
            errors++;
            $display("FAIL wrap i%0d: got %0d want %0d", i, InstrCount, i % 16);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      op = 4'b0010; mw = 1'b0;
      repeat (4) tick();
      op = 4'b0100;
      repeat (3) tick();
      mw = 1'b1;
      #1;
      checks++;
      if ({Step, Stall, InstrCount} !== {3'd4, 1'b1, 4'd1}) begin
         errors++;
         $display("FAIL mid_setup: got step=%0d stl=%b cnt=%0d want 4 1 1", Step, Stall, InstrCount);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({IRLoad, Stall, Retire} !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset_strobes: got %b want 000", {IRLoad, Stall, Retire});
      end
      tick();
      rst = 1'b0; mw = 1'b0;
      @(negedge clk);
      checks++;
      if ({Step, InstrCount, Halted} !== {3'd1, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset_state: got step=%0d cnt=%0d halt=%b want 1 0 0", Step, InstrCount, Halted);
      end
   endtask

   function automatic int last_of(input logic [3:0] o);
      if (o == 4'b1111) return 2;
      case (o[3:2])
         2'b00:   return 4;
         2'b01:   return 5;
         2'b10:   return 4;
         default: return 3;
      endcase
   endfunction

   task automatic test_random();
      int m_step, m_last, m_cnt, eff_last;
      bit m_halt, m_ldst, e_stall, e_irl, e_ret;
      logic [15:0] got, want;
      do_reset();
      m_step = 1; m_last = 4; m_cnt = 0; m_halt = 0; m_ldst = 0;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         op  = 4'($urandom_range(0, 15));
         mw  = ($urandom_range(0, 2) == 0);
         res = ($urandom_range(0, 5) == 0);
         eff_last = (m_step == 2) ? last_of(op) : m_last;
         e_stall = !rst && !m_halt && mw && (m_step == 1 || (m_step == 4 && m_ldst));
         e_irl   = !rst && !m_halt && m_step == 1 && !mw;
         e_ret   = !rst && !m_halt && m_step == eff_last && !e_stall;
         want = {3'(m_step), (m_step == 0) ? 5'd0 : 5'(1 << (m_step - 1)),
                 e_irl, e_stall, e_ret, 4'(m_cnt), m_halt};
         @(negedge clk);
         got = {Step, StepOneHot, IRLoad, Stall, Retire, InstrCount, Halted};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL random c%0d: got %h want %h (step,oh,irl,stl,ret,cnt,halt)", c, got, want);
         end
         tick();
         if (rst) begin
            m_step = 1; m_halt = 0; m_cnt = 0; m_last = 4; m_ldst = 0;
         end else if (m_halt) begin
            if (res) begin m_halt = 0; m_step = 1; end
         end else begin
            if (m_step == 2) begin
               m_last = last_of(op);
               m_ldst = (op[3:2] == 2'b01) || (op[3:2] == 2'b10);
            end
            if (e_stall) begin
               // step held
            end else if (e_ret) begin
               m_cnt = (m_cnt + 1) % 16;
               if (eff_last == 2) begin m_halt = 1; m_step = 0; end
               else m_step = 1;
            end else begin
               m_step++;
            end
         end
      end
      rst = 1'b0; res = 1'b0; mw = 1'b0;
   endtask

   initial begin
      rst = 1'b1; mw = 1'b0; res = 1'b0; op = 4'd0;
      test_reset();
      test_alu();
      test_load_stall();
      test_branch();
      test_halt();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
